// File: rtl/pixel_sensor_model_pkg.sv
// Shared types and default sizing for the clocked pixel-sensor model.
package pixel_sensor_model_pkg;

    localparam int unsigned DEFAULT_PIXEL_BITS   = 8;
    localparam int unsigned DEFAULT_EXPOSE_SHIFT = 2;
    localparam int unsigned DEFAULT_CHANNELS     = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASED  = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } sensor_state_t;

endpackage

// File: rtl/pixel_sensor_model_channel.sv
// One modelled pixel: saturating light accumulator plus sticky ramp-compare latch.
// Define PIXEL_SENSOR_DARK_CURRENT_EN to add one extra count per accepted expose step.
module pixel_channel
    import pixel_sensor_model_pkg::*;
#(
    parameter int unsigned PIXEL_BITS   = DEFAULT_PIXEL_BITS,
    parameter int unsigned EXPOSE_SHIFT = DEFAULT_EXPOSE_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  expose_en,
    input  logic                  ramp_en,
    input  logic [PIXEL_BITS-1:0] intensity,
    input  logic [PIXEL_BITS-1:0] ramp_cnt,
    output logic                  cmp,
    output logic                  cmp_next_c
);

    localparam int unsigned ACC_BITS = PIXEL_BITS + EXPOSE_SHIFT;
    localparam int unsigned SUM_BITS = ACC_BITS + 1;

    logic [ACC_BITS-1:0]   acc_q;
    logic [ACC_BITS-1:0]   acc_d;
    logic [SUM_BITS-1:0]   sum_c;
    logic [PIXEL_BITS-1:0] level_c;

`ifdef PIXEL_SENSOR_DARK_CURRENT_EN
    assign sum_c = SUM_BITS'(acc_q) + SUM_BITS'(intensity) + SUM_BITS'(1);
`else
    assign sum_c = SUM_BITS'(acc_q) + SUM_BITS'(intensity);
`endif

    assign level_c = acc_q[ACC_BITS-1:EXPOSE_SHIFT];

    // Next accumulator / compare state; the carry bit of sum_c signals saturation
    always_comb begin
        acc_d      = acc_q;
        cmp_next_c = cmp;
        if (clear) begin
            acc_d      = '0;
            cmp_next_c = 1'b0;
        end else begin
            if (expose_en) begin
                acc_d = sum_c[ACC_BITS] ? '1 : sum_c[ACC_BITS-1:0];
            end
            if (ramp_en && (ramp_cnt >= level_c)) begin
                cmp_next_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cmp   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cmp   <= cmp_next_c;
        end
    end

endmodule

// File: rtl/pixel_sensor_model.sv
// Multi-channel pixel-sensor model: sequencing FSM, shared ramp counter, done/seq_err.
// PIXEL_SENSOR_DARK_CURRENT_EN (optional) enables dark-current integration in each channel.
module pixel_sensor_model
    import pixel_sensor_model_pkg::*;
#(
    parameter int unsigned PIXEL_BITS   = DEFAULT_PIXEL_BITS,
    parameter int unsigned CHANNELS     = DEFAULT_CHANNELS,
    parameter int unsigned EXPOSE_SHIFT = DEFAULT_EXPOSE_SHIFT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           erase,
    input  logic                           expose,
    input  logic                           ramp,
    input  logic [CHANNELS*PIXEL_BITS-1:0] intensity,
    output logic [CHANNELS-1:0]            cmp,
    output logic [PIXEL_BITS-1:0]          ramp_cnt,
    output sensor_state_t                  state,
    output logic                           done,
    output logic                           seq_err
);

    localparam logic [PIXEL_BITS-1:0] RAMP_MAX = '1;

    sensor_state_t         state_d;
    logic [PIXEL_BITS-1:0] ramp_cnt_d;
    logic                  done_d;
    logic                  seq_err_d;
    logic                  clear_c;
    logic                  expose_en_c;
    logic                  ramp_en_c;
    logic [CHANNELS-1:0]   cmp_next_c;

    // Strobe arbitration: erase beats expose beats ramp, only legal states accept a step
    assign clear_c     = erase;
    assign expose_en_c = !erase && expose && ((state == S_ERASED) || (state == S_EXPOSE));
    assign ramp_en_c   = !erase && !expose && ramp &&
                         ((state == S_ERASED) || (state == S_EXPOSE) || (state == S_CONVERT));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pixel_channel #(
            .PIXEL_BITS  (PIXEL_BITS),
            .EXPOSE_SHIFT(EXPOSE_SHIFT)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear_c),
            .expose_en (expose_en_c),
            .ramp_en   (ramp_en_c),
            .intensity (intensity[c*PIXEL_BITS +: PIXEL_BITS]),
            .ramp_cnt  (ramp_cnt),
            .cmp       (cmp[c]),
            .cmp_next_c(cmp_next_c[c])
        );
    end

    always_comb begin
        state_d    = state;
        ramp_cnt_d = ramp_cnt;
        done_d     = done;
        seq_err_d  = seq_err;
        if (erase) begin
            state_d    = S_ERASED;
            ramp_cnt_d = '0;
            done_d     = 1'b0;
            seq_err_d  = 1'b0;
        end else if (expose) begin
            if (expose_en_c) begin
                state_d = S_EXPOSE;
            end else begin
                seq_err_d = 1'b1;
            end
        end else if (ramp) begin
            if (ramp_en_c) begin
                if (ramp_cnt != RAMP_MAX) begin
                    ramp_cnt_d = PIXEL_BITS'(ramp_cnt + 1'b1);
                end
                // Enter DONE on the same edge the last compare latch rises
                if (&cmp_next_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_CONVERT;
                end
            end else if (state == S_IDLE) begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ramp_cnt <= '0;
            done     <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_d;
            ramp_cnt <= ramp_cnt_d;
            done     <= done_d;
            seq_err  <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_pixel_sensor_model.sv
// Self-checking bench for pixel_sensor_model (PIXEL_BITS=8, EXPOSE_SHIFT=2, CHANNELS=2).
module tb_pixel_sensor_model;
    import pixel_sensor_model_pkg::*;

`ifdef PIXEL_SENSOR_DARK_CURRENT_EN
    localparam int DARK = 1;
`else
    localparam int DARK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          erase = 1'b0;
    logic          expose = 1'b0;
    logic          ramp = 1'b0;
    logic [15:0]   intensity = '0;
    logic [1:0]    cmp;
    logic [7:0]    ramp_cnt;
    sensor_state_t state;
    logic          done;
    logic          seq_err;

    always #5 clk = ~clk;

    pixel_sensor_model #(
        .PIXEL_BITS  (8),
        .CHANNELS    (2),
        .EXPOSE_SHIFT(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .erase    (erase),
        .expose   (expose),
        .ramp     (ramp),
        .intensity(intensity),
        .cmp      (cmp),
        .ramp_cnt (ramp_cnt),
        .state    (state),
        .done     (done),
        .seq_err  (seq_err)
    );

    typedef struct {
        logic [1:0]    cmp;
        logic [7:0]    rc;
        sensor_state_t st;
        logic          done;
        logic          err;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        er;
        logic        ex;
        logic        rp;
        logic [15:0] inten;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference state
    int            m_acc[2] = '{0, 0};
    logic [1:0]    m_cmp = '0;
    int            m_rc = 0;
    sensor_state_t m_st = S_IDLE;
    logic          m_done = 1'b0;
    logic          m_err = 1'b0;

    function automatic vec_t mk(input logic r, input logic e, input logic x, input logic p,
                                input logic [15:0] in, input logic [1:0] c, input logic [7:0] rc,
                                input sensor_state_t st, input logic d, input logic err);
        vec_t v;
        v.rst = r; v.er = e; v.ex = x; v.rp = p; v.inten = in;
        v.e.cmp = c; v.e.rc = rc; v.e.st = st; v.e.done = d; v.e.err = err;
        return v;
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void model_step(input logic r, input logic e, input logic x, input logic p,
                                       input logic [15:0] in);
        if (r || e) begin
            m_acc[0] = 0; m_acc[1] = 0; m_cmp = '0; m_rc = 0;
            m_done = 1'b0; m_err = 1'b0;
            m_st = r ? S_IDLE : S_ERASED;
        end else if (x) begin
            if (m_st == S_ERASED || m_st == S_EXPOSE) begin
                for (int c = 0; c < 2; c++) begin
                    m_acc[c] = m_acc[c] + int'(in[c*8 +: 8]) + DARK;
                    if (m_acc[c] > 1023) m_acc[c] = 1023;
                end
                m_st = S_EXPOSE;
            end else begin
                m_err = 1'b1;
            end
        end else if (p) begin
            if (m_st == S_IDLE) begin
                m_err = 1'b1;
            end else if (m_st != S_DONE) begin
                for (int c = 0; c < 2; c++) begin
                    if (m_rc >= m_acc[c] / 4) m_cmp[c] = 1'b1;
                end
                if (m_rc < 255) m_rc++;
                if (m_cmp == 2'b11) begin
                    m_st = S_DONE;
                    m_done = 1'b1;
                end else begin
                    m_st = S_CONVERT;
                end
            end
        end
    endfunction

    // Drive one cycle, queue the expectation, pop and compare once the edge has passed
    task automatic drive(input logic r, input logic e, input logic x, input logic p,
                         input logic [15:0] in, input exp_t ex_val, input string tag);
        exp_t got;
        reset = r; erase = e; expose = x; ramp = p; intensity = in;
        exp_q.push_back(ex_val);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            check_val({tag, " cmp"}, int'(cmp), int'(got.cmp));
            check_val({tag, " ramp_cnt"}, int'(ramp_cnt), int'(got.rc));
            check_val({tag, " state"}, int'(state), int'(got.st));
            check_val({tag, " done"}, int'(done), int'(got.done));
            check_val({tag, " seq_err"}, int'(seq_err), int'(got.err));
        end
    endtask

    task automatic step(input logic r, input logic e, input logic x, input logic p,
                        input logic [15:0] in, input string tag);
        exp_t ev;
        model_step(r, e, x, p, in);
        ev.cmp = m_cmp; ev.rc = 8'(m_rc); ev.st = m_st; ev.done = m_done; ev.err = m_err;
        drive(r, e, x, p, in, ev, tag);
    endtask

    vec_t tbl[14];

    initial begin
        int first0;
        int first1;
        int first_all;

        // Sequencing / priority vectors: ch0=4, ch1=8 give levels 1 and 2 with or without dark current
        tbl[0]  = mk(1, 1, 1, 1, 16'h0000, 2'b00, 8'd0, S_IDLE,    0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 16'h0000, 2'b00, 8'd0, S_IDLE,    0, 1);
        tbl[2]  = mk(0, 0, 1, 0, 16'h0000, 2'b00, 8'd0, S_IDLE,    0, 1);
        tbl[3]  = mk(0, 1, 0, 1, 16'h0000, 2'b00, 8'd0, S_ERASED,  0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 16'h0804, 2'b00, 8'd0, S_EXPOSE,  0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 16'h0804, 2'b00, 8'd1, S_CONVERT, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 16'h0804, 2'b00, 8'd1, S_CONVERT, 0, 1);
        tbl[7]  = mk(0, 0, 0, 1, 16'h0804, 2'b01, 8'd2, S_CONVERT, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, 16'h0804, 2'b11, 8'd3, S_DONE,    1, 1);
        tbl[9]  = mk(0, 0, 0, 1, 16'h0804, 2'b11, 8'd3, S_DONE,    1, 1);
        tbl[10] = mk(0, 0, 1, 0, 16'h0804, 2'b11, 8'd3, S_DONE,    1, 1);
        tbl[11] = mk(0, 1, 1, 0, 16'h0804, 2'b00, 8'd0, S_ERASED,  0, 0);
        tbl[12] = mk(0, 0, 0, 1, 16'h0804, 2'b11, 8'd1, S_DONE,    1, 0);
        tbl[13] = mk(1, 1, 0, 1, 16'h0804, 2'b00, 8'd0, S_IDLE,    0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].er, tbl[i].ex, tbl[i].rp, tbl[i].inten, tbl[i].e,
                  $sformatf("vec%0d", i));
        end

        // Two-level conversion: ch0=40, ch1=10
        step(1, 0, 0, 0, 16'h0000, "t2 reset");
        step(0, 1, 0, 0, 16'h0A28, "t2 erase");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0A28, "t2 expose");
        first0 = 0;
        first1 = 0;
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, 1, 16'h0A28, "t2 ramp");
            if (first0 == 0 && cmp[0]) first0 = i;
            if (first1 == 0 && cmp[1]) first1 = i;
        end
        check_val("t2 cmp1 strobe", first1, 11 + DARK);
        check_val("t2 cmp0 strobe", first0, 41 + DARK);
        check_val("t2 done", int'(done), 1);

        // Erase aborts a conversion in progress
        step(0, 1, 0, 0, 16'h0A28, "t4 erase");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0A28, "t4 expose");
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 16'h0A28, "t4 ramp");
        check_val("t4 cmp before abort", int'(cmp), 2);
        step(0, 1, 0, 1, 16'h0A28, "t4 abort");
        check_val("t4 cmp after abort", int'(cmp), 0);
        check_val("t4 ramp_cnt after abort", int'(ramp_cnt), 0);
        check_val("t4 state after abort", int'(state), int'(S_ERASED));

        // Saturated accumulator and saturated ramp
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'hFFFF, "t3 expose");
        first_all = 0;
        for (int i = 1; i <= 260; i++) begin
            step(0, 0, 0, 1, 16'hFFFF, "t3 ramp");
            if (first_all == 0 && cmp == 2'b11) first_all = i;
        end
        check_val("t3 full-scale strobe", first_all, 256);
        check_val("t3 ramp_cnt held", int'(ramp_cnt), 255);
        check_val("t3 state", int'(state), int'(S_DONE));

        // Dark pixel
        step(0, 1, 0, 0, 16'h0000, "t6 erase");
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000, "t6 expose");
        first0 = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 1, 16'h0000, "t6 ramp");
            if (first0 == 0 && cmp[0]) first0 = i;
        end
        check_val("t6 dark strobe", first0, 1 + 2 * DARK);

        check_val("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
